// File: rtl/clock_fallback_controller_if.sv
// Select/request/acknowledge handshake between the clock fallback controller
// and the external glitch-free clock multiplexer.
interface clock_fallback_controller_if #(
    parameter int CHANNELS = 2
);
    localparam int SELECT_WIDTH = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [SELECT_WIDTH-1:0] select;
    logic                    switch_request;
    logic                    switch_acknowledge;

    modport master (
        output select,
        output switch_request,
        input  switch_acknowledge
    );

    modport slave (
        input  select,
        input  switch_request,
        output switch_acknowledge
    );
endinterface

// File: rtl/clock_fallback_controller.sv
// Priority clock supervisor: heartbeat liveness per channel, lowest-index qualified
// channel wins, mux driven via handshake. Define CLOCK_FALLBACK_CONTROLLER_HOLDOFF_EN for switch-back hysteresis.
module clock_fallback_controller #(
    parameter int CHANNELS = 2,
    parameter int STAGES   = 2,
    parameter int TIMEOUT  = 16,
    parameter int RECOVERY = 256
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] heartbeat,
    input  logic [CHANNELS-1:0] channel_enable,
    output logic [CHANNELS-1:0] channel_alive,
    output logic                no_clock,
    clock_fallback_controller_if.master mux
);
    localparam int SELECT_WIDTH = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int COUNT_WIDTH  = $clog2(TIMEOUT + 1);

    if (CHANNELS < 2 || STAGES < 1 || TIMEOUT < 2 || RECOVERY < 1) begin : g_bad_params
        $error("clock_fallback_controller: illegal parameter set");
    end

    typedef enum logic {
        LOCKED,
        SWITCHING
    } state_t;

    logic [STAGES-1:0]      sync_q  [CHANNELS];
    logic [COUNT_WIDTH-1:0] count_q [CHANNELS];
    logic [CHANNELS-1:0]    delay_q;
    logic [CHANNELS-1:0]    edge_seen;
    logic [CHANNELS-1:0]    qualified;

    state_t                  state_q, state_d;
    logic [SELECT_WIDTH-1:0] select_q, select_d;
    logic                    request_q, request_d;
    logic [SELECT_WIDTH-1:0] target;
    logic                    target_valid;

    // Heartbeat synchronizer, edge detector and timeout counter per channel.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, which keeps the shift chain a chain.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                sync_q[i]  <= '0;
                count_q[i] <= '0;
            end
            delay_q <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                sync_q[i]  <= (sync_q[i] << 1) | STAGES'(heartbeat[i]);
                delay_q[i] <= sync_q[i][STAGES-1];
                if (edge_seen[i]) begin
                    count_q[i] <= COUNT_WIDTH'(TIMEOUT);
                end else if (count_q[i] != '0) begin
                    count_q[i] <= count_q[i] - 1'b1;
                end
            end
        end
    end

    // NOTE: every variable written in an always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        edge_seen     = '0;
        channel_alive = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            edge_seen[i]     = sync_q[i][STAGES-1] ^ delay_q[i];
            channel_alive[i] = (count_q[i] != '0);
        end
    end

    assign no_clock = ~|(channel_alive & channel_enable);

`ifdef CLOCK_FALLBACK_CONTROLLER_HOLDOFF_EN
    localparam int STABLE_WIDTH = $clog2(RECOVERY + 1);

    logic [STABLE_WIDTH-1:0] stable_q [CHANNELS];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                stable_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (!channel_alive[i]) begin
                    stable_q[i] <= '0;
                end else if (stable_q[i] != STABLE_WIDTH'(RECOVERY)) begin
                    stable_q[i] <= stable_q[i] + 1'b1;
                end
            end
        end
    end

    // Higher-priority channels than the current one must prove stability first.
    always_comb begin
        qualified = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            qualified[i] = channel_alive[i] && channel_enable[i] &&
                           ((SELECT_WIDTH'(i) >= select_q) ||
                            (stable_q[i] == STABLE_WIDTH'(RECOVERY)));
        end
    end
`else
    assign qualified = channel_alive & channel_enable;
`endif

    // Lowest-index qualified channel: scan downwards so the last hit wins.
    always_comb begin
        target       = '0;
        target_valid = 1'b0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (qualified[i]) begin
                target       = SELECT_WIDTH'(i);
                target_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= LOCKED;
            select_q  <= '0;
            request_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            select_q  <= select_d;
            request_q <= request_d;
        end
    end

    // While a switch is outstanding the multiplexer owns the select value, so
    // target changes are deliberately ignored until it acknowledges.
    always_comb begin
        state_d   = state_q;
        select_d  = select_q;
        request_d = request_q;
        case (state_q)
            LOCKED: begin
                if (target_valid && (target != select_q)) begin
                    select_d  = target;
                    request_d = 1'b1;
                    state_d   = SWITCHING;
                end
            end
            SWITCHING: begin
                if (mux.switch_acknowledge) begin
                    request_d = 1'b0;
                    state_d   = LOCKED;
                end
            end
            default: begin
                state_d   = LOCKED;
                request_d = 1'b0;
            end
        endcase
    end

    assign mux.select         = select_q;
    assign mux.switch_request = request_q;

endmodule

// File: tb/tb_clock_fallback_controller.sv
// Self-checking bench for clock_fallback_controller: vector table for steady
// states, request scoreboard, and directed sequences for timing corners.
module tb_clock_fallback_controller;
    localparam int CHANNELS = 2;
    localparam int STAGES   = 2;
    localparam int TIMEOUT  = 16;
    localparam int RECOVERY = 256;
`ifdef CLOCK_FALLBACK_CONTROLLER_HOLDOFF_EN
    localparam int HOLD = RECOVERY;
`else
    localparam int HOLD = 0;
`endif
    localparam int SETTLE = 48 + HOLD;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic [CHANNELS-1:0] heartbeat = '0;
    logic [CHANNELS-1:0] channel_enable = '0;
    logic [CHANNELS-1:0] channel_alive;
    logic                no_clock;

    logic [3:0] heartbeat4 = '0;
    logic [3:0] enable4 = '0;
    logic [3:0] alive4;
    logic       no_clock4;

    clock_fallback_controller_if #(.CHANNELS(CHANNELS)) bus ();
    clock_fallback_controller_if #(.CHANNELS(4)) bus4 ();

    clock_fallback_controller #(
        .CHANNELS(CHANNELS), .STAGES(STAGES), .TIMEOUT(TIMEOUT), .RECOVERY(RECOVERY)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .heartbeat      (heartbeat),
        .channel_enable (channel_enable),
        .channel_alive  (channel_alive),
        .no_clock       (no_clock),
        .mux            (bus)
    );

    clock_fallback_controller #(
        .CHANNELS(4), .STAGES(STAGES), .TIMEOUT(TIMEOUT), .RECOVERY(RECOVERY)
    ) dut4 (
        .clock          (clock),
        .reset          (reset),
        .heartbeat      (heartbeat4),
        .channel_enable (enable4),
        .channel_alive  (alive4),
        .no_clock       (no_clock4),
        .mux            (bus4)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0] run;
        logic [1:0] en;
        bit         sw;
        logic [1:0] alive;
        logic       nc;
        int         sel;
    } vec_t;

    int         n_checks = 0;
    int         n_bad = 0;
    int         cycle = 0;
    int         exp_q[$];
    logic [1:0] run = '0;
    logic [1:0] kick = '0;
    logic [3:0] run4 = '0;
    int         div[CHANNELS];
    int         div4[4];
    int         last_toggle[CHANNELS];
    bit         auto_ack = 1'b0;
    logic       req_prev = 1'b0;
    vec_t       vecs[9];

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // One reference cycle: drive just after posedge, sample at negedge.
    task automatic step(input int n);
        int e;
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
            cycle++;
            for (int i = 0; i < CHANNELS; i++) begin
                if (kick[i]) begin
                    heartbeat[i]   = ~heartbeat[i];
                    last_toggle[i] = cycle;
                end else if (run[i]) begin
                    div[i]++;
                    if (div[i] >= 4) begin
                        div[i]         = 0;
                        heartbeat[i]   = ~heartbeat[i];
                        last_toggle[i] = cycle;
                    end
                end
            end
            kick = '0;
            for (int i = 0; i < 4; i++) begin
                if (run4[i]) begin
                    div4[i]++;
                    if (div4[i] >= 4) begin
                        div4[i]       = 0;
                        heartbeat4[i] = ~heartbeat4[i];
                    end
                end
            end
            if (auto_ack) bus.switch_acknowledge = bus.switch_request;
            bus4.switch_acknowledge = bus4.switch_request;
            @(negedge clock);
            if (bus.switch_request && !req_prev) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_bad++;
                    $display("FAIL unexpected_request: select=%0d expected no request", bus.select);
                end else begin
                    e = exp_q.pop_front();
                    check("request_select", int'(bus.select), e);
                end
            end
            req_prev = bus.switch_request;
        end
    endtask

    initial begin
        int alive_cnt;
        int guard;
        int fall;
        int n;
        int stable;

        for (int i = 0; i < CHANNELS; i++) begin
            div[i] = 0;
            last_toggle[i] = 0;
        end
        for (int i = 0; i < 4; i++) div4[i] = 0;

        vecs[0] = '{run: 2'b10, en: 2'b11, sw: 1'b0, alive: 2'b10, nc: 1'b0, sel: 1};
        vecs[1] = '{run: 2'b11, en: 2'b11, sw: 1'b1, alive: 2'b11, nc: 1'b0, sel: 0};
        vecs[2] = '{run: 2'b11, en: 2'b10, sw: 1'b1, alive: 2'b11, nc: 1'b0, sel: 1};
        vecs[3] = '{run: 2'b11, en: 2'b00, sw: 1'b0, alive: 2'b11, nc: 1'b1, sel: 1};
        vecs[4] = '{run: 2'b01, en: 2'b11, sw: 1'b1, alive: 2'b01, nc: 1'b0, sel: 0};
        vecs[5] = '{run: 2'b00, en: 2'b11, sw: 1'b0, alive: 2'b00, nc: 1'b1, sel: 0};
        vecs[6] = '{run: 2'b10, en: 2'b01, sw: 1'b0, alive: 2'b10, nc: 1'b1, sel: 0};
        vecs[7] = '{run: 2'b10, en: 2'b11, sw: 1'b1, alive: 2'b10, nc: 1'b0, sel: 1};
        vecs[8] = '{run: 2'b11, en: 2'b11, sw: 1'b1, alive: 2'b11, nc: 1'b0, sel: 0};

        bus.switch_acknowledge  = 1'b0;
        bus4.switch_acknowledge = 1'b0;
        channel_enable = 2'b11;
        reset = 1'b1;
        step(3);
        check("reset_alive", int'(channel_alive), 0);
        check("reset_no_clock", int'(no_clock), 1);
        check("reset_select", int'(bus.select), 0);
        check("reset_request", int'(bus.switch_request), 0);
        check("reset4_select", int'(bus4.select), 0);
        check("reset4_alive", int'(alive4), 0);
        reset = 1'b0;

        // Single heartbeat edge on channel 1: rise latency, request, alive width.
        exp_q.push_back(1);
        kick = 2'b10;
        step(STAGES + 1);
        check("a_alive_early", int'(channel_alive), 0);
        step(1);
        check("a_alive_rise", int'(channel_alive), 2);
        alive_cnt = 1;
        step(1);
        check("a_request", int'(bus.switch_request), 1);
        alive_cnt += int'(channel_alive[1]);
        bus.switch_acknowledge = 1'b1;
        step(1);
        bus.switch_acknowledge = 1'b0;
        check("a_request_drop", int'(bus.switch_request), 0);
        check("a_no_clock_low", int'(no_clock), 0);
        alive_cnt += int'(channel_alive[1]);
        guard = 0;
        while (channel_alive[1] && guard < 100) begin
            step(1);
            guard++;
            if (channel_alive[1]) alive_cnt++;
        end
        check("a_alive_width", alive_cnt, TIMEOUT);
        check("a_dead_no_clock", int'(no_clock), 1);
        check("a_dead_select_holds", int'(bus.select), 1);

        // Steady-state vector table with the bench acknowledging every switch.
        auto_ack = 1'b1;
        for (int r = 0; r < 9; r++) begin
            run = vecs[r].run;
            channel_enable = vecs[r].en;
            if (vecs[r].sw) exp_q.push_back(vecs[r].sel);
            step(SETTLE);
            check($sformatf("row%0d_alive", r), int'(channel_alive), int'(vecs[r].alive));
            check($sformatf("row%0d_no_clock", r), int'(no_clock), int'(vecs[r].nc));
            check($sformatf("row%0d_select", r), int'(bus.select), vecs[r].sel);
            check($sformatf("row%0d_request", r), int'(bus.switch_request), 0);
        end

        // Four channels, 1 and 3 alive, channel 1 masked then unmasked.
        run4 = 4'b1010;
        enable4 = 4'b1101;
        step(SETTLE);
        check("c4_alive", int'(alive4), 4'b1010);
        check("c4_select_masked", int'(bus4.select), 3);
        check("c4_no_clock", int'(no_clock4), 0);
        enable4 = 4'b1111;
        step(SETTLE);
        check("c4_select_unmasked", int'(bus4.select), 1);

        // Fallback: channel 0 stops, alive falls TIMEOUT after its last edge.
        auto_ack = 1'b0;
        bus.switch_acknowledge = 1'b0;
        run[0] = 1'b0;
        exp_q.push_back(1);
        guard = 0;
        while (channel_alive[0] && guard < 100) begin
            step(1);
            guard++;
        end
        fall = cycle;
        check("b_alive_fall_time", fall - last_toggle[0], STAGES + 1 + TIMEOUT);
        check("b_request_not_yet", int'(bus.switch_request), 0);
        step(1);
        check("b_request", int'(bus.switch_request), 1);
        bus.switch_acknowledge = 1'b1;
        step(1);
        bus.switch_acknowledge = 1'b0;
        check("b_request_drop", int'(bus.switch_request), 0);

        // Switch-back once channel 0 recovers.
        run[0] = 1'b1;
        exp_q.push_back(0);
        guard = 0;
        while (!channel_alive[0] && guard < 100) begin
            step(1);
            guard++;
        end
        check("c_alive_rise", int'(channel_alive[0]), 1);
        check("c_no_request_at_rise", int'(bus.switch_request), 0);
        n = 0;
        while (!bus.switch_request && n < HOLD + 20) begin
            step(1);
            n++;
        end
        check("c_switch_back_delay", n, HOLD + 1);

        // Acknowledge withheld 20 cycles while the target changes twice.
        stable = 0;
        for (int k = 0; k < 20; k++) begin
            if (k == 6) channel_enable = 2'b00;
            if (k == 13) channel_enable = 2'b10;
            step(1);
            if (bus.select == 1'b0 && bus.switch_request) stable++;
        end
        check("d_held_stable", stable, 20);
        exp_q.push_back(1);
        bus.switch_acknowledge = 1'b1;
        step(1);
        bus.switch_acknowledge = 1'b0;
        check("d_request_drop", int'(bus.switch_request), 0);
        step(1);
        check("d_rerequest", int'(bus.switch_request), 1);

        // Reset in the middle of a handshake.
        reset = 1'b1;
        step(1);
        check("e_reset_request", int'(bus.switch_request), 0);
        check("e_reset_select", int'(bus.select), 0);
        check("e_reset_alive", int'(channel_alive), 0);
        check("e_reset_no_clock", int'(no_clock), 1);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule

// File: doc/clock_fallback_controller.md
# clock_fallback_controller

Priority-based clock supervisor for CHANNELS candidate clocks, running entirely in one free-running reference clock domain. Each candidate clock supplies a heartbeat (a toggle or divided copy generated in its own domain). The block declares each channel alive or dead from that heartbeat and picks the highest-priority alive channel. It then drives an external glitch-free clock multiplexer through a select/request/acknowledge handshake, generalising the two-clock fallback to N channels with timeouts and switch-back hysteresis.

## Interface
- CHANNELS, 2, number of candidate clocks; index 0 is highest priority; minimum 2
- STAGES, 2, synchronizer depth for each heartbeat input
- TIMEOUT, 16, reference cycles without a heartbeat edge before a channel is declared dead; minimum 2
- RECOVERY, 256, reference cycles a recovered higher-priority channel must stay alive before switch-back (used only with the holdoff feature)
- SELECT_WIDTH, max(1, $clog2(CHANNELS)), derived; not overridable
- Ports:
  - clock  in  1  free-running reference clock
  - reset  in  1  synchronous, active-high reset
  - heartbeat  in  CHANNELS  per-channel heartbeat, asynchronous to clock; each must toggle at most once per 2 reference cycles
  - channel_enable  in  CHANNELS  software mask; a disabled channel is never selected
  - switch_acknowledge  in  1  multiplexer has completed the switch to select
  - select  out  SELECT_WIDTH  channel index driven to the multiplexer
  - switch_request  out  1  a new select value is pending acknowledge
  - channel_alive  out  CHANNELS  per-channel liveness
  - no_clock  out  1  no channel is both alive and enabled

## Operation
- Per channel:
  - The heartbeat passes through a STAGES flop synchronizer, then one delay flop. An edge is detected when these two differ.
  - Timeout counter of width $clog2(TIMEOUT+1). It reloads to TIMEOUT on each edge and otherwise decrements, saturating at 0.
  - channel_alive = (counter != 0).
- Qualified set: alive AND enabled.
- Target: the lowest-index qualified channel.
- FSM states:
  - LOCKED:
    - If no channel is qualified: no_clock=1, select holds, stay in LOCKED.
    - Else if target != select: load select with target, assert switch_request, go to SWITCHING.
  - SWITCHING:
    - select and switch_request are held.
    - Target changes are ignored.
    - When switch_acknowledge=1: deassert switch_request, go to LOCKED, and re-evaluate from the next cycle.
- Fallback (current channel dead or disabled) switches immediately to the next qualified channel.
- A lower-priority channel never displaces the current one while the current one is still qualified.
- switch_acknowledge while in LOCKED is ignored.
- Reset values:
  - All counters 0.
  - channel_alive all 0, no_clock 1.
  - select 0, switch_request 0.
  - State LOCKED.
  - Synchronizer flops 0.
- Reset asserted mid-handshake aborts it: switch_request drops in the cycle after reset is sampled.

## Timing
- Heartbeat edge to channel_alive rising: STAGES+2 cycles.
- Last detected edge to channel_alive falling: exactly TIMEOUT cycles.
- no_clock is combinational from the registered alive/enable state, so it changes in the same cycle as channel_alive or channel_enable.
- The qualified-set change and select/switch_request updating are separated by one cycle, registered together.
- switch_request falls the cycle after switch_acknowledge is sampled high. The earliest next request is one cycle later.
- If a channel is alive for 1 cycle and dead the next, a switch already requested still completes. Fallback follows after the acknowledge.

## Configuration
- CLOCK_FALLBACK_CONTROLLER_HOLDOFF_EN
- Defined:
  - Each channel has a stability counter that counts up to RECOVERY while alive (saturating) and clears on dead.
  - A channel with index < select qualifies only once its stability counter = RECOVERY.
  - Channels with index >= select qualify as soon as they are alive.
- Undefined:
  - No stability counters.
  - Switch-back to a higher-priority channel occurs as soon as it is alive and enabled.

## Test plan
- Reset, then channel 1 heartbeat toggling every 4 cycles, channel 0 silent:
  - channel_alive=2'b10 after STAGES+2 cycles.
  - switch_request with select=1.
  - After acknowledge, switch_request=0 and no_clock=0.
- Both channels running and select=0; stop channel 0 heartbeat:
  - channel_alive[0] falls exactly TIMEOUT cycles after the last edge.
  - Next cycle: select=1, switch_request=1.
- Restart channel 0 (HOLDOFF_EN defined, RECOVERY=256):
  - No request for 256 cycles after channel_alive[0] rises.
  - Then select=0 with a request.
  - Without the macro, the request follows 1 cycle after channel_alive[0] rises.
- CHANNELS=4, channels 1 and 3 alive, channel_enable=4'b1101:
  - select=3.
  - Setting channel_enable[1]=1 gives select=1 (with HOLDOFF_EN, once channel 1's stability counter reaches RECOVERY).
- Hold switch_acknowledge low for 20 cycles while the target changes twice:
  - select and switch_request stay stable.
  - After acknowledge, re-evaluation issues a new request to the current target.
- Kill all heartbeats:
  - no_clock=1 TIMEOUT cycles later, and select holds.
  - Assert reset mid-SWITCHING: switch_request=0, select=0, channel_alive=0 the next cycle.
